// File: rtl/cpu_decode_queued_if.sv
// ============================================================================
//  Module      : cpu_decode_queued_if
//  Description : Fetch-side and execute-side signal bundle of the queued decoder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cpu_decode_queued_if #(
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 4
);
  localparam int c_cw = $clog2(DEPTH) + 1;

  logic                 i_flush;
  logic                 i_stall;
  logic [TAG_WIDTH-1:0] i_tag;
  logic [31:0]          i_instruction;
  logic [31:0]          i_pc;

  logic                 o_full;
  logic [TAG_WIDTH-1:0] o_tag;
  logic [31:0]          o_instruction;
  logic [31:0]          o_pc;
  logic [4:0]           o_inst_rs1;
  logic [4:0]           o_inst_rs2;
  logic [4:0]           o_inst_rd;
  logic [31:0]          o_imm;
  logic [2:0]           o_format;
  logic [3:0]           o_op;
  logic                 o_illegal;
  logic [c_cw-1:0]      o_count;

  modport master (
    output i_flush, i_stall, i_tag, i_instruction, i_pc,
    input  o_full, o_tag, o_instruction, o_pc, o_inst_rs1, o_inst_rs2, o_inst_rd,
           o_imm, o_format, o_op, o_illegal, o_count
  );

  modport slave (
    input  i_flush, i_stall, i_tag, i_instruction, i_pc,
    output o_full, o_tag, o_instruction, o_pc, o_inst_rs1, o_inst_rs2, o_inst_rd,
           o_imm, o_format, o_op, o_illegal, o_count
  );
endinterface

`default_nettype wire

// File: rtl/cpu_decode_queued.sv
// ============================================================================
//  Module      : cpu_decode_queued
//  Description : RV32 decode stage behind a DEPTH-entry instruction queue,
//                tag-change handshake on both sides. Optional macro
//                DECODE_BYPASS_EN decodes straight from fetch when empty.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_decode_queued #(
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 4
) (
  input  wire logic          i_clock,
  input  wire logic          i_reset,
  cpu_decode_queued_if.slave bus
);
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_pw = c_aw + 1;

  localparam logic [2:0] c_fmt_r    = 3'd0;
  localparam logic [2:0] c_fmt_i    = 3'd1;
  localparam logic [2:0] c_fmt_s    = 3'd2;
  localparam logic [2:0] c_fmt_b    = 3'd3;
  localparam logic [2:0] c_fmt_u    = 3'd4;
  localparam logic [2:0] c_fmt_j    = 3'd5;
  localparam logic [2:0] c_fmt_none = 3'd7;
  localparam logic [3:0] c_op_ill   = 4'd15;

  logic [31:0]          r_mem_instr [DEPTH];
  logic [31:0]          r_mem_pc    [DEPTH];
  logic [c_pw-1:0]      r_wr_ptr, r_rd_ptr;
  logic                 r_full;
  logic [TAG_WIDTH-1:0] r_last_tag;

  logic [TAG_WIDTH-1:0] r_tag;
  logic [31:0]          r_instruction, r_pc, r_imm;
  logic [4:0]           r_rs1, r_rs2, r_rd;
  logic [2:0]           r_format;
  logic [3:0]           r_op;
  logic                 r_illegal;

  logic                 w_empty, w_new, w_accept, w_push, w_pop, w_bypass, w_load;
  logic [c_pw-1:0]      w_wr_next, w_rd_next;
  logic                 w_full_next;
  logic [TAG_WIDTH-1:0] w_tag_inc, w_tag_next;
  logic [31:0]          w_dec_instr, w_dec_pc;
  logic [31:0]          w_d_imm;
  logic [4:0]           w_d_rs1, w_d_rs2, w_d_rd;
  logic [2:0]           w_d_fmt;
  logic [3:0]           w_d_op;
  logic                 w_d_ill;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_new    = (bus.i_tag != r_last_tag);
  assign w_accept = w_new && !r_full && !bus.i_flush;

`ifdef DECODE_BYPASS_EN
  assign w_bypass = w_empty && w_new && !bus.i_stall && !bus.i_flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_accept && !w_bypass;
  assign w_pop  = !bus.i_stall && !w_empty && !bus.i_flush;
  assign w_load = w_pop || w_bypass;

  assign w_wr_next   = w_push ? r_wr_ptr + c_pw'(1) : r_wr_ptr;
  assign w_rd_next   = w_pop  ? r_rd_ptr + c_pw'(1) : r_rd_ptr;
  assign w_full_next = (w_wr_next[c_pw-1] != w_rd_next[c_pw-1]) &&
                       (w_wr_next[c_aw-1:0] == w_rd_next[c_aw-1:0]);

  // Tag 0 means "nothing since reset", so the output sequence wraps to 1
  assign w_tag_inc  = r_tag + TAG_WIDTH'(1);
  assign w_tag_next = (w_tag_inc == '0) ? TAG_WIDTH'(1) : w_tag_inc;

  assign w_dec_instr = w_bypass ? bus.i_instruction : r_mem_instr[r_rd_ptr[c_aw-1:0]];
  assign w_dec_pc    = w_bypass ? bus.i_pc          : r_mem_pc[r_rd_ptr[c_aw-1:0]];

  always_comb begin
    w_d_op  = c_op_ill;
    w_d_fmt = c_fmt_none;
    if (w_dec_instr[1:0] == 2'b11) begin
      case (w_dec_instr[6:2])
        5'b01101: begin w_d_op = 4'd0;  w_d_fmt = c_fmt_u; end
        5'b00101: begin w_d_op = 4'd1;  w_d_fmt = c_fmt_u; end
        5'b11011: begin w_d_op = 4'd2;  w_d_fmt = c_fmt_j; end
        5'b11001: begin w_d_op = 4'd3;  w_d_fmt = c_fmt_i; end
        5'b11000: begin w_d_op = 4'd4;  w_d_fmt = c_fmt_b; end
        5'b00000: begin w_d_op = 4'd5;  w_d_fmt = c_fmt_i; end
        5'b01000: begin w_d_op = 4'd6;  w_d_fmt = c_fmt_s; end
        5'b00100: begin w_d_op = 4'd7;  w_d_fmt = c_fmt_i; end
        5'b01100: begin w_d_op = 4'd8;  w_d_fmt = c_fmt_r; end
        5'b00011: begin w_d_op = 4'd9;  w_d_fmt = c_fmt_i; end
        5'b11100: begin w_d_op = 4'd10; w_d_fmt = c_fmt_i; end
        default:  ;
      endcase
    end
    w_d_ill = (w_d_op == c_op_ill);

    // Field presence is a function of format; illegal falls to all-zero
    w_d_rs1 = '0;
    w_d_rs2 = '0;
    w_d_rd  = '0;
    w_d_imm = '0;
    case (w_d_fmt)
      c_fmt_r: begin
        w_d_rs1 = w_dec_instr[19:15];
        w_d_rs2 = w_dec_instr[24:20];
        w_d_rd  = w_dec_instr[11:7];
      end
      c_fmt_i: begin
        w_d_rs1 = w_dec_instr[19:15];
        w_d_rd  = w_dec_instr[11:7];
        w_d_imm = {{20{w_dec_instr[31]}}, w_dec_instr[31:20]};
      end
      c_fmt_s: begin
        w_d_rs1 = w_dec_instr[19:15];
        w_d_rs2 = w_dec_instr[24:20];
        w_d_imm = {{20{w_dec_instr[31]}}, w_dec_instr[31:25], w_dec_instr[11:7]};
      end
      c_fmt_b: begin
        w_d_rs1 = w_dec_instr[19:15];
        w_d_rs2 = w_dec_instr[24:20];
        w_d_imm = {{19{w_dec_instr[31]}}, w_dec_instr[31], w_dec_instr[7],
                   w_dec_instr[30:25], w_dec_instr[11:8], 1'b0};
      end
      c_fmt_u: begin
        w_d_rd  = w_dec_instr[11:7];
        w_d_imm = {w_dec_instr[31:12], 12'b0};
      end
      c_fmt_j: begin
        w_d_rd  = w_dec_instr[11:7];
        w_d_imm = {{11{w_dec_instr[31]}}, w_dec_instr[31], w_dec_instr[19:12],
                   w_dec_instr[20], w_dec_instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr[c_aw-1:0]] <= bus.i_instruction;
      r_mem_pc[r_wr_ptr[c_aw-1:0]]    <= bus.i_pc;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_full        <= 1'b0;
      r_last_tag    <= '0;
      r_tag         <= '0;
      r_instruction <= '0;
      r_pc          <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_rd          <= '0;
      r_imm         <= '0;
      r_format      <= c_fmt_none;
      r_op          <= '0;
      r_illegal     <= 1'b0;
    end else begin
      if (bus.i_flush) begin
        // Adopting the current tag discards the fetch that is in flight
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_full     <= 1'b0;
        r_last_tag <= bus.i_tag;
      end else begin
        r_wr_ptr <= w_wr_next;
        r_rd_ptr <= w_rd_next;
        r_full   <= w_full_next;
        if (w_accept) begin
          r_last_tag <= bus.i_tag;
        end
      end
      if (w_load) begin
        r_tag         <= w_tag_next;
        r_instruction <= w_dec_instr;
        r_pc          <= w_dec_pc;
        r_rs1         <= w_d_rs1;
        r_rs2         <= w_d_rs2;
        r_rd          <= w_d_rd;
        r_imm         <= w_d_imm;
        r_format      <= w_d_fmt;
        r_op          <= w_d_op;
        r_illegal     <= w_d_ill;
      end
    end
  end

  assign bus.o_full        = r_full;
  assign bus.o_count       = r_wr_ptr - r_rd_ptr;
  assign bus.o_tag         = r_tag;
  assign bus.o_instruction = r_instruction;
  assign bus.o_pc          = r_pc;
  assign bus.o_inst_rs1    = r_rs1;
  assign bus.o_inst_rs2    = r_rs2;
  assign bus.o_inst_rd     = r_rd;
  assign bus.o_imm         = r_imm;
  assign bus.o_format      = r_format;
  assign bus.o_op          = r_op;
  assign bus.o_illegal     = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_cpu_decode_queued.sv
// ============================================================================
//  Module      : tb_cpu_decode_queued
//  Description : Scoreboard bench for cpu_decode_queued (DEPTH 4, TAG_WIDTH 4).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cpu_decode_queued;
  localparam int DEPTH     = 4;
  localparam int TAG_WIDTH = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [3:0]  op;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_decode_queued_if #(.DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH)) bus ();

  cpu_decode_queued #(.DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  exp_t                 sb[$];
  int                   n_checks = 0;
  int                   n_fail   = 0;
  logic [TAG_WIDTH-1:0] exp_out_tag = '0;
  logic [TAG_WIDTH-1:0] in_tag      = '0;
  logic [31:0]          pc_cnt      = 32'h0000_1000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t               e;
    int                 f;
    logic signed [11:0] ii;
    logic signed [11:0] ss;
    logic signed [12:0] bb;
    logic signed [20:0] jj;
    e       = '0;
    e.instr = ins;
    e.pc    = pc;
    e.op    = 4'd15;
    f       = 7;
    case (ins[6:0])
      7'h37: begin e.op = 4'd0;  f = 4; end
      7'h17: begin e.op = 4'd1;  f = 4; end
      7'h6F: begin e.op = 4'd2;  f = 5; end
      7'h67: begin e.op = 4'd3;  f = 1; end
      7'h63: begin e.op = 4'd4;  f = 3; end
      7'h03: begin e.op = 4'd5;  f = 1; end
      7'h23: begin e.op = 4'd6;  f = 2; end
      7'h13: begin e.op = 4'd7;  f = 1; end
      7'h33: begin e.op = 4'd8;  f = 0; end
      7'h0F: begin e.op = 4'd9;  f = 1; end
      7'h73: begin e.op = 4'd10; f = 1; end
      default: ;
    endcase
    e.fmt = 3'(f);
    e.ill = (f == 7);
    ii = ins[31:20];
    ss = {ins[31:25], ins[11:7]};
    bb = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    jj = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    if (f == 0 || f == 1 || f == 2 || f == 3) e.rs1 = ins[19:15];
    if (f == 0 || f == 2 || f == 3)           e.rs2 = ins[24:20];
    if (f == 0 || f == 1 || f == 4 || f == 5) e.rd  = ins[11:7];
    case (f)
      1: e.imm = 32'(ii);
      2: e.imm = 32'(ss);
      3: e.imm = 32'(bb);
      4: e.imm = {ins[31:12], 12'h000};
      5: e.imm = 32'(jj);
      default: e.imm = '0;
    endcase
    return e;
  endfunction

  // Each change of o_tag is one decoded instruction; compare it to the oldest expected entry
  always @(negedge clk) begin
    logic [TAG_WIDTH-1:0] nt;
    exp_t                 e;
    if (rst) begin
      exp_out_tag = '0;
      sb.delete();
    end else if (bus.o_tag !== exp_out_tag) begin
      nt = exp_out_tag + 1'b1;
      if (nt == '0) nt = 1;
      check("o_tag_seq", 64'(bus.o_tag), 64'(nt));
      exp_out_tag = nt;
      if (sb.size() == 0) begin
        check("unexpected_output", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        check("out_instr",   64'(bus.o_instruction), 64'(e.instr));
        check("out_pc",      64'(bus.o_pc),          64'(e.pc));
        check("out_rs1",     64'(bus.o_inst_rs1),    64'(e.rs1));
        check("out_rs2",     64'(bus.o_inst_rs2),    64'(e.rs2));
        check("out_rd",      64'(bus.o_inst_rd),     64'(e.rd));
        check("out_imm",     64'(bus.o_imm),         64'(e.imm));
        check("out_format",  64'(bus.o_format),      64'(e.fmt));
        check("out_op",      64'(bus.o_op),          64'(e.op));
        check("out_illegal", 64'(bus.o_illegal),     64'(e.ill));
      end
    end
  end

  task automatic present(input logic [31:0] ins);
    in_tag            = in_tag + 1'b1;
    bus.i_tag         = in_tag;
    bus.i_instruction = ins;
    bus.i_pc          = pc_cnt;
    sb.push_back(ref_decode(ins, pc_cnt));
    pc_cnt            = pc_cnt + 4;
  endtask

  // Returns just after the edge that took the presented instruction
  task automatic wait_accept();
    logic full;
    int   n;
    n    = 0;
    full = 1'b1;
    while (full && n < 200) begin
      @(negedge clk);
      full = bus.o_full;
      @(posedge clk);
      #1;
      n++;
    end
    if (full) check("accept_timeout", 64'(1), 64'(0));
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.i_stall = 1'b0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", 64'(sb.size()), 64'(0));
  endtask

  logic [31:0] tbl [8];
  logic [TAG_WIDTH-1:0] held_tag;

  initial begin
    tbl[0] = 32'h002081B3;  // add  x3,x1,x2
    tbl[1] = 32'h123452B7;  // lui  x5,0x12345
    tbl[2] = 32'hFE112E23;  // sw   x1,-4(x2)
    tbl[3] = 32'h008000EF;  // jal  x1,+8
    tbl[4] = 32'hFFC0A183;  // lw   x3,-4(x1)
    tbl[5] = 32'h00000073;  // ecall
    tbl[6] = 32'h00001097;  // auipc x1,1
    tbl[7] = 32'h000300E7;  // jalr x1,0(x6)

    bus.i_flush       = 1'b0;
    bus.i_stall       = 1'b0;
    bus.i_tag         = '0;
    bus.i_instruction = '0;
    bus.i_pc          = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_count",  64'(bus.o_count),  64'(0));
    check("rst_full",   64'(bus.o_full),   64'(0));
    check("rst_tag",    64'(bus.o_tag),    64'(0));
    check("rst_format", 64'(bus.o_format), 64'(7));

    // One instruction out, then three queued under stall, then async reset
    present(tbl[0]);
    wait_accept();
    drain();
    bus.i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      present(tbl[i + 1]);
      wait_accept();
    end
    check("q3_count", 64'(bus.o_count), 64'(3));
    #1 rst = 1'b1;
    #1;
    check("arst_count", 64'(bus.o_count),       64'(0));
    check("arst_tag",   64'(bus.o_tag),         64'(0));
    check("arst_full",  64'(bus.o_full),        64'(0));
    check("arst_instr", 64'(bus.o_instruction), 64'(0));
    check("arst_pc",    64'(bus.o_pc),          64'(0));
    check("arst_rs1",   64'(bus.o_inst_rs1),    64'(0));
    check("arst_fmt",   64'(bus.o_format),      64'(7));
    in_tag      = '0;
    bus.i_tag   = '0;
    bus.i_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ADDI x5,x1,-3 latency and decode
    present(32'hFFD08293);
    check("addi_pre_tag", 64'(bus.o_tag), 64'(0));
    @(posedge clk);
    #1;
`ifdef DECODE_BYPASS_EN
    check("addi_tag_edge_n", 64'(bus.o_tag), 64'(1));
`else
    check("addi_tag_edge_n", 64'(bus.o_tag), 64'(0));
    @(posedge clk);
    #1;
    check("addi_tag_edge_n1", 64'(bus.o_tag), 64'(1));
`endif
    check("addi_op",  64'(bus.o_op),       64'(7));
    check("addi_fmt", 64'(bus.o_format),   64'(1));
    check("addi_rs1", 64'(bus.o_inst_rs1), 64'(1));
    check("addi_rs2", 64'(bus.o_inst_rs2), 64'(0));
    check("addi_rd",  64'(bus.o_inst_rd),  64'(5));
    check("addi_imm", 64'(bus.o_imm),      64'hFFFF_FFFD);
    drain();

    // BEQ x1,x2,-8 and an illegal opcode
    present(32'hFE208CE3);
    wait_accept();
    drain();
    check("beq_op",  64'(bus.o_op),      64'(4));
    check("beq_fmt", 64'(bus.o_format),  64'(3));
    check("beq_rd",  64'(bus.o_inst_rd), 64'(0));
    check("beq_imm", 64'(bus.o_imm),     64'hFFFF_FFF8);
    present(32'h0000007F);
    wait_accept();
    drain();
    check("ill_flag", 64'(bus.o_illegal), 64'(1));
    check("ill_op",   64'(bus.o_op),      64'(15));
    check("ill_fmt",  64'(bus.o_format),  64'(7));
    check("ill_imm",  64'(bus.o_imm),     64'(0));

    // Fill under stall, one more held by o_full, then release
    bus.i_stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      present(tbl[i + 2]);
      wait_accept();
    end
    check("fill_full",  64'(bus.o_full),  64'(1));
    check("fill_count", 64'(bus.o_count), 64'(DEPTH));
    held_tag = exp_out_tag;
    present(tbl[7]);
    repeat (3) @(posedge clk);
    #1;
    check("held_full",  64'(bus.o_full),  64'(1));
    check("held_count", 64'(bus.o_count), 64'(DEPTH));
    check("held_tag",   64'(bus.o_tag),   64'(held_tag));
    bus.i_stall = 1'b0;
    wait_accept();
    drain();

    // Flush with two queued and a new fetch in flight
    bus.i_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      present(tbl[i]);
      wait_accept();
    end
    check("preflush_count", 64'(bus.o_count), 64'(2));
    held_tag          = exp_out_tag;
    in_tag            = in_tag + 1'b1;
    bus.i_tag         = in_tag;
    bus.i_instruction = 32'h00100093;
    bus.i_flush       = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    sb.delete();
    check("flush_count", 64'(bus.o_count), 64'(0));
    check("flush_full",  64'(bus.o_full),  64'(0));
    check("flush_tag",   64'(bus.o_tag),   64'(held_tag));
    bus.i_stall = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("flush_no_emit", 64'(bus.o_tag), 64'(held_tag));
    present(tbl[3]);
    wait_accept();
    drain();

    // Mixed traffic with random stalls; carries o_tag through its wrap
    for (int i = 0; i < 14; i++) begin
      bus.i_stall = (sb.size() < DEPTH) ? ($urandom_range(0, 2) == 0) : 1'b0;
      present((i % 4 == 3) ? $urandom : tbl[$urandom_range(0, 7)]);
      wait_accept();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
